// File: rtl/nes_poll_sequencer.sv
// Two-pad NES controller poll sequencer: drives the shared latch/pulse lines from
// the system clock, samples both serial data lines in parallel and publishes a snapshot.
module nes_poll_sequencer #(
  parameter int TICK_DIV = 300
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       data_p1,
  input  logic       data_p2,
  output logic       latch_out,
  output logic       pulse_out,
  output logic       busy,
  output logic       valid,
  output logic       overrun,
  output logic [7:0] buttons_p1,
  output logic [7:0] buttons_p2,
  output logic [7:0] pressed_p1,
  output logic [7:0] pressed_p2
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LATCH    = 2'd1,
    SHIFT_LO = 2'd2,
    PULSE_HI = 2'd3
  } state_t;

  localparam logic [15:0] LAST_TICK = 16'(TICK_DIV - 1);

  state_t      state;
  state_t      state_nxt;
  logic        start_q;
  logic        start_edge;
  logic        pad1_sync_p0;
  logic        pad1_sync_p1;
  logic        pad2_sync_p0;
  logic        pad2_sync_p1;
  logic [15:0] phase_cnt;
  logic        period_end;
  logic        latch_half;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_p1;
  logic [7:0]  shift_p2;
  logic [7:0]  asm_p1;
  logic [7:0]  asm_p2;
  logic        sample;
  logic        commit;
  logic        latch_nxt;
  logic        pulse_nxt;
  logic        busy_nxt;
  logic        overrun_nxt;

  // Input conditioning: idle data lines read as released; start edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pad1_sync_p0 <= 1'b1;
      pad1_sync_p1 <= 1'b1;
      pad2_sync_p0 <= 1'b1;
      pad2_sync_p1 <= 1'b1;
      start_q      <= 1'b0;
    end else begin
      pad1_sync_p0 <= data_p1;
      pad1_sync_p1 <= pad1_sync_p0;
      pad2_sync_p0 <= data_p2;
      pad2_sync_p1 <= pad2_sync_p0;
      start_q      <= start;
    end
  end

  assign start_edge = start & ~start_q;
  assign period_end = (phase_cnt == LAST_TICK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start_edge) state_nxt = LATCH;
      LATCH:    if (period_end && latch_half) state_nxt = SHIFT_LO;
      SHIFT_LO: if (period_end) state_nxt = (bit_idx == 3'd7) ? IDLE : PULSE_HI;
      PULSE_HI: if (period_end) state_nxt = SHIFT_LO;
      default:  state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the upcoming state.
  always_comb begin
    latch_nxt   = (state_nxt == LATCH);
    pulse_nxt   = (state_nxt == PULSE_HI);
    busy_nxt    = (state_nxt != IDLE);
    sample      = (state == SHIFT_LO) && period_end;
    commit      = sample && (bit_idx == 3'd7);
    overrun_nxt = start_edge && (state != IDLE);
  end

  // Phase counter restarts on every period end and every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_cnt  <= 16'd0;
      latch_half <= 1'b0;
      bit_idx    <= 3'd0;
    end else begin
      if ((state == IDLE) || (state_nxt != state) || period_end) begin
        phase_cnt <= 16'd0;
      end else begin
        phase_cnt <= phase_cnt + 16'd1;
      end
      if (state != LATCH) begin
        latch_half <= 1'b0;
      end else if (period_end) begin
        latch_half <= ~latch_half;
      end
      if (state == LATCH) begin
        bit_idx <= 3'd0;
      end else if ((state == PULSE_HI) && period_end) begin
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  // First bit (A) lands in bit 7; the final sample is folded in before commit.
  always_comb begin
    asm_p1 = shift_p1;
    asm_p2 = shift_p2;
    if (sample) begin
      asm_p1[3'd7 - bit_idx] = ~pad1_sync_p1;
      asm_p2[3'd7 - bit_idx] = ~pad2_sync_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (sample) begin
      shift_p1 <= asm_p1;
      shift_p2 <= asm_p2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_out  <= 1'b0;
      pulse_out  <= 1'b0;
      busy       <= 1'b0;
      valid      <= 1'b0;
      overrun    <= 1'b0;
      buttons_p1 <= 8'h00;
      buttons_p2 <= 8'h00;
      pressed_p1 <= 8'h00;
      pressed_p2 <= 8'h00;
    end else begin
      latch_out <= latch_nxt;
      pulse_out <= pulse_nxt;
      busy      <= busy_nxt;
      valid     <= commit;
      overrun   <= overrun_nxt;
      if (commit) begin
        buttons_p1 <= asm_p1;
        buttons_p2 <= asm_p2;
        pressed_p1 <= asm_p1 & ~buttons_p1;
        pressed_p2 <= asm_p2 & ~buttons_p2;
      end
    end
  end

endmodule
